// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: turns a scanned 6-digit 7-segment bus into BCD frames; SEG_DEC_TIMEOUT_EN adds a frame timeout
module seg_scan_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [5:0]  sel,
    input  logic [7:0]  seg,
    output logic [23:0] display_val_bcd,
    output logic [5:0]  dp,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        timeout
);
    localparam int CW = $clog2(STABLE_CYC + 1);

    if (STABLE_CYC < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("seg_scan_decoder: STABLE_CYC must be >= 2 and TIMEOUT_CYC >= 1");
    end

    logic [13:0]   in_q;
    logic [13:0]   prev_q;
    logic [CW-1:0] cnt;
    logic [5:0]    s_sel;
    logic [7:0]    s_seg;
    logic [5:0]    seen;
    logic [23:0]   shadow;
    logic [5:0]    shadow_dp;
    logic [3:0]    nib;
    logic          hold;
    logic          take;
    logic          bad;
    logic          bad_pat;
    logic          complete;
    logic          tclr;

    assign s_sel = in_q[13:8];
    assign s_seg = in_q[7:0];
    assign hold  = in_q == prev_q;
    // the strobe fires on the edge where the counter steps from STABLE_CYC-2 to STABLE_CYC-1,
    // so the value sampled is still the one that has been stable in in_q
    assign take  = hold && cnt == CW'(STABLE_CYC - 2) && s_sel != 6'd0 && (s_sel & (s_sel - 6'd1)) == 6'd0;

    // Segment pattern to BCD; anything unrecognised becomes F and marks the frame bad
    always_comb begin
        nib     = 4'hF;
        bad_pat = 1'b0;
        case (s_seg[6:0])
            7'h40:   nib = 4'd0;
            7'h79:   nib = 4'd1;
            7'h24:   nib = 4'd2;
            7'h30:   nib = 4'd3;
            7'h19:   nib = 4'd4;
            7'h12:   nib = 4'd5;
            7'h02:   nib = 4'd6;
            7'h78:   nib = 4'd7;
            7'h00:   nib = 4'd8;
            7'h10:   nib = 4'd9;
            default: bad_pat = 1'b1;
        endcase
    end

    // Input stage, stability counter, shadow capture and frame publication
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            in_q            <= '0;
            prev_q          <= '0;
            cnt             <= '0;
            seen            <= '0;
            bad             <= 1'b0;
            shadow          <= '0;
            shadow_dp       <= '0;
            complete        <= 1'b0;
            display_val_bcd <= '0;
            dp              <= '0;
            seg_err         <= 1'b0;
            frame_valid     <= 1'b0;
        end else begin
            in_q     <= {sel, seg};
            prev_q   <= in_q;
            cnt      <= !hold ? '0 : (cnt == CW'(STABLE_CYC)) ? cnt : cnt + 1'b1;
            complete <= take && (seen | s_sel) == 6'h3F;
            seen     <= ((complete || tclr) ? 6'd0 : seen) | (take ? s_sel : 6'd0);
            bad      <= ((complete || tclr) ? 1'b0 : bad) | (take && bad_pat);
            if (take)
                for (int i = 0; i < 6; i++)
                    if (s_sel[i]) begin
                        shadow[4*i +: 4] <= nib;
                        shadow_dp[i]     <= ~s_seg[7];
                    end
            if (complete) begin
                display_val_bcd <= shadow;
                dp              <= shadow_dp;
                seg_err         <= bad;
            end
            frame_valid <= complete;
        end
    end

`ifdef SEG_DEC_TIMEOUT_EN
    logic [31:0] tcnt;

    // a publishing frame always wins over a coinciding timeout
    assign tclr = !complete && tcnt == 32'(TIMEOUT_CYC - 1);

    // Frame watchdog: restarts on reset release or publication, drops a stale partial frame
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= (complete || tclr) ? '0 : tcnt + 32'd1;
            timeout <= tclr;
        end
    end
`else
    assign tclr    = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, min 2: cycles {sel,seg} must hold unchanged before a digit is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000: max cycles between completed frames; used only when SEG_DEC_TIMEOUT_EN is defined.
REQ-003 SHALL have port sys_clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sel, input, 6 bits: one-hot, active-high digit select; sel[i] selects digit i.
REQ-006 SHALL have port seg, input, 8 bits: active-low segments; seg[7]=dp, seg[6:0]=g..a.
REQ-007 SHALL have port display_val_bcd, output, 24 bits: last complete frame; digit i in bits [4i+3:4i].
REQ-008 SHALL have port dp, output, 6 bits: captured decimal points, active-high (dp[i] = ~seg[7] at digit i's sample).
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when display_val_bcd/dp update.
REQ-010 SHALL have port seg_err, output, 1 bit: level; set if the last published frame held any undecodable digit.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse on frame timeout (tied 0 without SEG_DEC_TIMEOUT_EN).

Function
REQ-012 SHALL register {sel,seg} once (input stage) before any comparison.
REQ-013 SHALL keep a stability counter: cleared when the registered value differs from its previous cycle, otherwise incremented, saturating at STABLE_CYC.
REQ-014 SHALL generate exactly one sample strobe per dwell, on the cycle the counter reaches STABLE_CYC-1; a dwell shorter than STABLE_CYC cycles produces no sample.
REQ-015 SHALL ignore samples where sel is zero or not one-hot (no state change).
REQ-016 SHALL decode seg[6:0]: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7, 0x00->8, 0x10->9; any other pattern -> nibble 4'hF and frame bad flag set.
REQ-017 SHALL write the decoded nibble and dp bit into shadow slot i and set seen[i]; re-sampling a seen digit overwrites the slot without error.
REQ-018 SHALL, when a sample makes seen == 6'b111111, on the next edge copy shadow to display_val_bcd/dp, pulse frame_valid, load seg_err from the bad flag (including the completing sample), clear seen and bad flag.
REQ-019 SHALL give latency from the completing digit's first appearance at the ports to frame_valid of STABLE_CYC+1 cycles.
REQ-020 SHALL hold display_val_bcd, dp, seg_err stable between frame_valid pulses.
REQ-021 SHALL have digit order irrelevant; frames complete on any scan order.

Reset
REQ-022 SHALL, while rst=1, clear display_val_bcd=0, dp=0, frame_valid=0, seg_err=0, timeout=0, seen=0, shadow=0, bad flag=0, counters=0, input register=0.
REQ-023 SHALL, on reset mid-frame, discard the partial frame; first frame after release requires all six digits re-sampled.

Configuration
REQ-024 SHALL, with SEG_DEC_TIMEOUT_EN defined, count cycles since reset release or last frame_valid; on reaching TIMEOUT_CYC pulse timeout, clear seen and bad flag, restart count; published outputs unchanged.
REQ-025 SHALL, with SEG_DEC_TIMEOUT_EN undefined, contain no timeout counter, tie timeout to 0, and keep partial frames indefinitely.
REQ-026 SHALL, if frame completion and timeout coincide, give frame completion priority (frame_valid=1, timeout=0, counter restarts).

Verification
REQ-027 SHALL verify: scan digits 0..5 showing 1,2,3,4,5,6 (8 cycles each, STABLE_CYC=4) -> frame_valid once, display_val_bcd=24'h654321, seg_err=0.
REQ-028 SHALL verify: digit 2 seg=0x7F (blank), others valid -> frame_valid, display_val_bcd[11:8]=4'hF, seg_err=1; next clean frame -> seg_err=0.
REQ-029 SHALL verify: 2-cycle glitch sel=6'b000100 seg=0x00 between dwells -> no sample, digit 2 value unchanged.
REQ-030 SHALL verify: rst pulsed after digits 0..3 captured -> outputs 0; frame_valid only after all six digits rescanned.
REQ-031 SHALL verify: scan order 5,3,1,0,2,4 with digit 3 dp=0 (seg[7]=0) -> frame_valid, dp=6'b001000.
REQ-032 SHALL verify (SEG_DEC_TIMEOUT_EN, TIMEOUT_CYC=100): only digits 0..2 scanned for 100 cycles -> timeout pulse, seen cleared, display_val_bcd unchanged.
